seq_detector_prog: RTL and testbench

Runtime-programmable serial bit-pattern detector and the parametrised successor to our fixed-pattern "0110" shift detector. It accepts one qualified bit per cycle and compares the most recent cfg_len bits against a programmed pattern. On a match it emits a one-cycle pulse and increments a saturating match counter. Overlapping or non-overlapping detection is selectable. It sits on serial framing and sync-word paths, fed by a deserialiser front end.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detector_prog.sv | 155 +++++++++++++++
 tb/tb_seq_detector_prog.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

    // FILL: fewer than len bits collected since the last clear.
    // HUNT: window is full, every accepted bit is compared.
    // ERR : latched length is illegal; input bits are ignored.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        HUNT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc yields 1.
// Latency: count reflects inc/clr one cycle after the edge they are sampled on.
// Backpressure: none; inc is accepted every cycle, held at all-ones when saturated.
//
// Ports: clk, reset (async, active-high), inc (count one event), clr (sync clear),
//        count (current saturating value).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(CNT_W-1){1'b0}}, inc};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Latency: detect_out is high the cycle after the edge that samples the last pattern bit.
// Backpressure: none; din_valid low simply holds history, fill and state.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   din_valid, din_bit    qualified serial input, one bit per cycle
//   cfg_load              strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern           pattern, bit [len-1] arrives first, bit [0] last
//   cfg_len, cfg_overlap  pattern length (1..MAX_LEN) and overlap enable
//   count_clr             synchronous clear of match_count
//   detect_out            registered one-cycle match pulse
//   match_count           saturating number of matches
//   cfg_err               latched length is illegal
//   armed                 window holds at least len bits (HUNT)
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0110,
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detect_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    state_t               state_q, state_n;
    logic [MAX_LEN-1:0]   pattern_q, pattern_n;
    logic [LEN_W-1:0]     len_q, len_n;
    logic                 overlap_q, overlap_n;
    // Only MAX_LEN-1 bits are stored: the compare always works on the
    // post-shift window {hist_q, din_bit}, which is the full MAX_LEN bits.
    logic [MAX_LEN-2:0]   hist_q, hist_n;
    logic [LEN_W-1:0]     fill_q, fill_n;
    logic                 detect_n;
    logic                 cfg_err_n;
    logic                 match_evt;

    logic [MAX_LEN-1:0]   hist_shift;
    logic [MAX_LEN-1:0]   len_mask;
    logic [LEN_W-1:0]     fill_inc;
    logic                 cfg_legal;

    assign hist_shift = {hist_q, din_bit};
    assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    // Select the low len bits of the window for comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    always_comb begin
        state_n   = state_q;
        pattern_n = pattern_q;
        len_n     = len_q;
        overlap_n = overlap_q;
        hist_n    = hist_q;
        fill_n    = fill_q;
        detect_n  = 1'b0;
        cfg_err_n = cfg_err;
        match_evt = 1'b0;

        if (cfg_load) begin
            // Reconfiguration wins over any bit presented in the same cycle.
            pattern_n = cfg_pattern;
            len_n     = cfg_len;
            overlap_n = cfg_overlap;
            hist_n    = '0;
            fill_n    = '0;
            cfg_err_n = !cfg_legal;
            state_n   = cfg_legal ? FILL : ERR;
        end else if (din_valid) begin
            unique case (state_q)
                FILL, HUNT: begin
                    hist_n = hist_shift[MAX_LEN-2:0];
                    fill_n = fill_inc;
                    if ((fill_inc >= len_q) &&
                        (((hist_shift ^ pattern_q) & len_mask) == '0)) begin
                        match_evt = 1'b1;
                        detect_n  = 1'b1;
                        if (overlap_q) begin
                            state_n = HUNT;
                        end else begin
                            // Non-overlapping: the next match needs len fresh bits.
                            hist_n  = '0;
                            fill_n  = '0;
                            state_n = FILL;
                        end
                    end else begin
                        state_n = (fill_inc >= len_q) ? HUNT : FILL;
                    end
                end
                ERR: begin
                    state_n = ERR;
                end
                default: begin
                    state_n = ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            pattern_q  <= RST_PATTERN;
            len_q      <= LEN_W'(RST_LEN);
            overlap_q  <= RST_OVERLAP;
            hist_q     <= '0;
            fill_q     <= '0;
            detect_out <= 1'b0;
            cfg_err    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state_q    <= state_n;
            pattern_q  <= pattern_n;
            len_q      <= len_n;
            overlap_q  <= overlap_n;
            hist_q     <= hist_n;
            fill_q     <= fill_n;
            detect_out <= detect_n;
            cfg_err    <= cfg_err_n;
            armed      <= (state_n == HUNT);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_evt),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed scenarios plus random traffic.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: din_valid gaps exercised randomly and in directed gaps.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               reset;
    logic               din_valid;
    logic               din_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               detect_out;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    int checks   = 0;
    int failures = 0;

    seq_detector_prog #(
        .MAX_LEN     (MAX_LEN),
        .CNT_W       (CNT_W),
        .RST_PATTERN (8'b0000_0110),
        .RST_LEN     (4),
        .RST_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din_valid   (din_valid),
        .din_bit     (din_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .detect_out  (detect_out),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bits received since the last clear, in arrival order.
    bit [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ov;
    bit               m_err;
    bit               m_q[$];
    int               m_cnt;
    bit               m_det;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pat = 8'b0000_0110;
        m_len = 4;
        m_ov  = 1'b1;
        m_err = 1'b0;
        m_q.delete();
        m_cnt = 0;
        m_det = 1'b0;
    endfunction

    function automatic void model_cycle(input bit ld, input bit v, input bit b, input bit clr);
        bit hit;
        hit = 1'b0;
        if (ld) begin
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
            m_ov  = cfg_overlap;
            m_err = (m_len == 0) || (m_len > MAX_LEN);
            m_q.delete();
        end else if (v && !m_err) begin
            m_q.push_back(b);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
                if (hit && !m_ov) m_q.delete();
            end
        end
        m_det = hit;
        if (clr)                         m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    endfunction

    task automatic check_outputs();
        check("detect_out",  int'(detect_out),  int'(m_det));
        check("match_count", int'(match_count), m_cnt);
        check("armed",       int'(armed),       int'(!m_err && (m_q.size() >= m_len)));
        check("cfg_err",     int'(cfg_err),     int'(m_err));
    endtask

    task automatic step(input bit v, input bit b, input bit ld, input bit clr);
        @(negedge clk);
        din_valid = v;
        din_bit   = b;
        cfg_load  = ld;
        count_clr = clr;
        @(posedge clk);
        model_cycle(ld, v, b, clr);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        din_valid = 1'b0;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
        #1;
        model_reset();
        check("rst_detect", int'(detect_out), 0);
        check("rst_count",  int'(match_count), 0);
        check("rst_armed",  int'(armed), 0);
        check("rst_cfgerr", int'(cfg_err), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input int l, input bit ov);
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = ov;
        // A bit offered alongside the load must be dropped.
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    endtask

    task automatic send_seq(input logic [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, s[i], 1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        din_valid   = 1'b0;
        din_bit     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        count_clr   = 1'b0;
        model_reset();

        // Reset defaults, overlapping 0110 in 0110110.
        do_reset();
        send_seq(16'b0110110, 7);

        // Same stream, non-overlapping.
        load(8'b0110, 4, 1'b0);
        send_seq(16'b0110110, 7);

        // 101 overlapping with a valid gap between bits 2 and 3.
        load(8'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        send_seq(16'b101, 3);

        // len=1, saturation, then clear coincident with a match.
        load(8'b1, 1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        load(8'b1, 1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Illegal length, then recovery.
        load(8'b0110, 0, 1'b1);
        send_seq(16'b0110, 4);
        load(8'b0110, 12, 1'b1);
        send_seq(16'b0110, 4);
        load(8'b0110, 4, 1'b1);
        send_seq(16'b0110, 4);

        // Reset mid-pattern discards partial history.
        do_reset();
        send_seq(16'b011, 3);
        do_reset();
        send_seq(16'b0, 1);
        send_seq(16'b0110, 4);

        // Random traffic with occasional reconfiguration, clears and resets.
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 777) begin
                do_reset();
            end else if ($urandom_range(0, 59) == 0) begin
                int r;
                int l;
                r = $urandom_range(0, 19);
                if (r == 0)      l = 0;
                else if (r == 1) l = MAX_LEN + 1 + $urandom_range(0, 6);
                else if (r < 6)  l = $urandom_range(1, MAX_LEN);
                else             l = $urandom_range(1, 3);
                load(MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)));
            end else begin
                step($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 1'b0,
                     $urandom_range(0, 99) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
